sram_1r1w_ctrl: RTL and testbench
=================================

SRAM_1R1W_CTRL -- requirements
Module: sram_1r1w_ctrl

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 11, word address bits; DATA_WIDTH, 32, data bits; NUM_WMASKS, 4, byte lanes; RSP_DEPTH, 4, response FIFO entries (power of 2, >=2).
REQ-002 Ports (name direction width meaning): clk in 1 clock; reset is synchronous and active-low on nrst in 1.
REQ-003 Write request ports: wr_valid in 1; wr_ready out 1; wr_addr in ADDR_WIDTH; wr_data in DATA_WIDTH; wr_strb in NUM_WMASKS byte enables.
REQ-004 Read request ports: rd_valid in 1; rd_ready out 1; rd_addr in ADDR_WIDTH.
REQ-005 Read response ports: rsp_valid out 1; rsp_ready in 1; rsp_data out DATA_WIDTH.
REQ-006 Write-port SRAM pins: sram_csb0 out 1 (active low); sram_wmask0 out NUM_WMASKS; sram_addr0 out ADDR_WIDTH; sram_din0 out DATA_WIDTH.
REQ-007 Read-port SRAM pins: sram_csb1 out 1 (active low); sram_addr1 out ADDR_WIDTH; sram_dout1 in DATA_WIDTH.
REQ-008 Status port: busy out 1, high while any read is in flight or the response FIFO is non-empty.

Function
REQ-009 Both SRAM ports are clocked by clk.
REQ-010 A transfer occurs when valid and ready are both high at a rising edge.
REQ-011 Write path is combinational in the accepting cycle: sram_csb0 = ~(wr_valid & wr_ready & |wr_strb); sram_wmask0 = wr_strb; sram_addr0 = wr_addr; sram_din0 = wr_data.
REQ-012 A write with wr_strb == 0 is accepted (handshake completes) but leaves sram_csb0 high.
REQ-013 wr_ready is high whenever nrst is high.
REQ-014 Read issue is combinational in the accepting cycle N: sram_csb1 = ~(rd_valid & rd_ready); sram_addr1 = rd_addr.
REQ-015 sram_dout1 is sampled at the rising edge ending cycle N+1 and is never sampled at any other edge.
REQ-016 The sampled word is pushed into the response FIFO; rsp_valid is therefore first high in cycle N+2 for an empty FIFO.
REQ-017 An in-flight counter (0..2) tracks reads in stages N and N+1.
REQ-018 rd_ready = (fifo_count + inflight < RSP_DEPTH) & ~hazard; no accepted read is ever dropped.
REQ-019 hazard = wr_valid & |wr_strb & rd_valid & (wr_addr == rd_addr). The write proceeds; the read stalls one or more cycles.
REQ-020 Responses are returned in request order; rsp_data is the FIFO head, stable while rsp_valid & ~rsp_ready.
REQ-021 A simultaneous FIFO push and pop leaves the count unchanged; a pop when empty or a push when full cannot occur (REQ-018).
REQ-022 FIFO pointers wrap modulo RSP_DEPTH.
REQ-023 A write accepted in cycle N is visible to any read accepted in cycle N+1 or later.
REQ-024 Back-to-back reads sustain 1 read/cycle while rsp_ready stays high.

Reset
REQ-025 While nrst is low at a rising edge, the FIFO is flushed and inflight is set to 0.
REQ-026 Reset values: rsp_valid=0; busy=0; wr_ready=0; rd_ready=0; sram_csb0=1; sram_csb1=1; rsp_data=0.
REQ-027 Reads in flight when reset asserts are discarded, and their data never appears on rsp_data.
REQ-028 Requests are accepted from the first cycle with nrst high.

Structure
REQ-029 Default widths and RSP_DEPTH are defined as constants in a shared sram_ctrl_pkg.
REQ-030 Response buffering is a sub-module sram_rsp_fifo (sync FIFO with count output).
REQ-031 The SRAM macro is instantiated outside this block; this block contains no storage array beyond the FIFO.

Verification
REQ-032 Write 0xDEADBEEF to addr 0x005 with strb 0xF, then read 0x005 the next cycle -> rsp_valid 2 cycles after the read handshake, rsp_data=0xDEADBEEF.
REQ-033 Write 0x11223344 to addr 0x010 with strb 0xF, then 0xAABBCCDD with strb 0x5 -> read returns 0x11BB33DD.
REQ-034 Same-cycle write and read to 0x7FF -> write completes, rd_ready low that cycle, read returns the new data.
REQ-035 Hold rsp_ready=0 and stream reads to 0x000..0x009 -> exactly 4 accepted, then rd_ready=0. Release rsp_ready -> all 10 reads return in order with no loss.
REQ-036 Assert nrst low with 2 reads in flight and 1 read in the FIFO -> rsp_valid=0, busy=0, both csb pins high, and no stale response after release.
REQ-037 Write with strb 0x0 -> handshake completes, sram_csb0 stays 1, and memory is unchanged on readback.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared defaults and helpers for the 1R1W SRAM controller
package sram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WMASKS = 4;
  localparam int DEF_RSP_DEPTH  = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - synchronous response FIFO with occupancy count
module sram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/sram_1r1w_ctrl.sv
// rtl/sram_1r1w_ctrl.sv - 1R1W SRAM port controller with in-order read responses
module sram_1r1w_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WMASKS-1:0] wr_strb,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic                  busy
);

  localparam int CW = cnt_width(RSP_DEPTH);
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] OCC_LIM = OW'(RSP_DEPTH);

  logic          wr_fire;
  logic          rd_fire;
  logic          hazard;
  logic          rd_pend_q, rd_pend_d;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] occ;
  logic [1:0]    inflight;
  logic          rsp_pop;

  assign wr_ready = nrst;
  assign wr_fire  = wr_valid & wr_ready;

  assign sram_csb0   = ~(wr_fire & (|wr_strb));
  assign sram_wmask0 = wr_strb;
  assign sram_addr0  = wr_addr;
  assign sram_din0   = wr_data;

  // A read racing a same-address write waits so it observes the new data.
  assign hazard = wr_valid & (|wr_strb) & rd_valid & (wr_addr == rd_addr);

  // The read issued this cycle is not counted here, which keeps rd_ready free of
  // a loop through rd_valid; one free slot is then still guaranteed for it.
  assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q};
  assign rd_ready = nrst & (occ < OCC_LIM) & ~hazard;
  assign rd_fire  = rd_valid & rd_ready;

  assign sram_csb1  = ~rd_fire;
  assign sram_addr1 = rd_addr;

  assign rd_pend_d = rd_fire;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_pop   = rsp_valid & rsp_ready;

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (rd_pend_q),
    .din   (sram_dout1),
    .pop   (rsp_pop),
    .dout  (rsp_data),
    .count (fifo_count)
  );

  assign inflight = {1'b0, rd_fire} + {1'b0, rd_pend_q};
  assign busy     = (inflight != 2'd0) | (fifo_count != '0);

endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// tb/tb_sram_1r1w_ctrl.sv - directed vector bench for sram_1r1w_ctrl with an SRAM model
module tb_sram_1r1w_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid;
  logic        rd_ready;
  logic [10:0] rd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        sram_csb0;
  logic [3:0]  sram_wmask0;
  logic [10:0] sram_addr0;
  logic [31:0] sram_din0;
  logic        sram_csb1;
  logic [10:0] sram_addr1;
  logic [31:0] sram_dout1;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_1r1w_ctrl dut (
    .clk         (clk),
    .nrst        (nrst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .sram_csb0   (sram_csb0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (sram_dout1),
    .busy        (busy)
  );

  // SRAM model: output register holds junk on cycles without a read.
  logic [31:0] mem [2048];

  always @(posedge clk) begin
    if (!sram_csb0) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    else            sram_dout1 <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [10:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic rv, input logic [10:0] ra,
                       input logic rr);
    @(posedge clk);
    #1;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_strb = ws;
    rd_valid = rv; rd_addr = ra; rsp_ready = rr;
    @(negedge clk);
  endtask

  typedef struct {
    logic        wv;
    logic [10:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        rv;
    logic [10:0] ra;
    logic        rr;
    logic        e_rrdy;
    logic        e_csb0;
    logic        e_csb1;
    logic        e_rv;
    logic        e_busy;
    logic [31:0] e_d;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic [10:0] wa, input logic [31:0] wd,
                              input logic [3:0] ws, input logic rv, input logic [10:0] ra,
                              input logic rr, input logic e_rrdy, input logic e_csb0,
                              input logic e_csb1, input logic e_rv, input logic e_busy,
                              input logic [31:0] e_d);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.ws = ws; v.rv = rv; v.ra = ra; v.rr = rr;
    v.e_rrdy = e_rrdy; v.e_csb0 = e_csb0; v.e_csb1 = e_csb1;
    v.e_rv = e_rv; v.e_busy = e_busy; v.e_d = e_d;
    return v;
  endfunction

  function automatic logic [31:0] init_word(input int a);
    return 32'hC0DE_0000 | a;
  endfunction

  vec_t tbl [20];
  int idx;
  int got;
  logic [31:0] exp_d;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = init_word(i);

    tbl[0]  = mk(1, 11'h005, 32'hDEADBEEF, 4'hF, 0, 11'h000, 1,  1, 0, 1, 0, 0, 32'h0);
    tbl[1]  = mk(0, 11'h000, 32'h0,        4'h0, 1, 11'h005, 1,  1, 1, 0, 0, 1, 32'h0);
    tbl[2]  = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 1,  1, 1, 1, 0, 1, 32'h0);
    tbl[3]  = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 1,  1, 1, 1, 1, 1, 32'hDEADBEEF);
    tbl[4]  = mk(1, 11'h010, 32'h11223344, 4'hF, 0, 11'h000, 1,  1, 0, 1, 0, 0, 32'h0);
    tbl[5]  = mk(1, 11'h010, 32'hAABBCCDD, 4'h5, 0, 11'h000, 1,  1, 0, 1, 0, 0, 32'h0);
    tbl[6]  = mk(0, 11'h000, 32'h0,        4'h0, 1, 11'h010, 1,  1, 1, 0, 0, 1, 32'h0);
    tbl[7]  = mk(1, 11'h020, 32'h12345678, 4'h0, 0, 11'h000, 1,  1, 1, 1, 0, 1, 32'h0);
    tbl[8]  = mk(0, 11'h000, 32'h0,        4'h0, 1, 11'h020, 1,  1, 1, 0, 1, 1, 32'h11BB33DD);
    tbl[9]  = mk(0, 11'h000, 32'h0,        4'h0, 1, 11'h005, 1,  1, 1, 0, 0, 1, 32'h0);
    tbl[10] = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 1,  1, 1, 1, 1, 1, 32'hC0DE0020);
    tbl[11] = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 1,  1, 1, 1, 1, 1, 32'hDEADBEEF);
    tbl[12] = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 1,  1, 1, 1, 0, 0, 32'h0);
    tbl[13] = mk(1, 11'h7FF, 32'h55667788, 4'hF, 1, 11'h7FF, 1,  0, 0, 1, 0, 0, 32'h0);
    tbl[14] = mk(0, 11'h000, 32'h0,        4'h0, 1, 11'h7FF, 1,  1, 1, 0, 0, 1, 32'h0);
    tbl[15] = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 1,  1, 1, 1, 0, 1, 32'h0);
    tbl[16] = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 0,  1, 1, 1, 1, 1, 32'h55667788);
    tbl[17] = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 0,  1, 1, 1, 1, 1, 32'h55667788);
    tbl[18] = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 1,  1, 1, 1, 1, 1, 32'h55667788);
    tbl[19] = mk(0, 11'h000, 32'h0,        4'h0, 0, 11'h000, 1,  1, 1, 1, 0, 0, 32'h0);

    // Reset with live requests present: nothing may leak through.
    nrst = 1'b0;
    wr_valid = 1'b1; wr_addr = 11'h040; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
    rd_valid = 1'b1; rd_addr = 11'h040; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("rst_rd_ready", {31'b0, rd_ready}, 32'd0);
    chk("rst_csb0", {31'b0, sram_csb0}, 32'd1);
    chk("rst_csb1", {31'b0, sram_csb1}, 32'd1);
    chk("rst_rsp_data", rsp_data, 32'd0);

    @(posedge clk);
    #1;
    nrst = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0;

    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].wv, tbl[k].wa, tbl[k].wd, tbl[k].ws, tbl[k].rv, tbl[k].ra, tbl[k].rr);
      chk($sformatf("v%0d_wr_ready", k), {31'b0, wr_ready}, 32'd1);
      chk($sformatf("v%0d_rd_ready", k), {31'b0, rd_ready}, {31'b0, tbl[k].e_rrdy});
      chk($sformatf("v%0d_csb0", k), {31'b0, sram_csb0}, {31'b0, tbl[k].e_csb0});
      chk($sformatf("v%0d_csb1", k), {31'b0, sram_csb1}, {31'b0, tbl[k].e_csb1});
      chk($sformatf("v%0d_rsp_valid", k), {31'b0, rsp_valid}, {31'b0, tbl[k].e_rv});
      chk($sformatf("v%0d_busy", k), {31'b0, busy}, {31'b0, tbl[k].e_busy});
      if (tbl[k].e_rv) chk($sformatf("v%0d_rsp_data", k), rsp_data, tbl[k].e_d);
      if (tbl[k].wv) begin
        chk($sformatf("v%0d_wmask0", k), {28'b0, sram_wmask0}, {28'b0, tbl[k].ws});
        chk($sformatf("v%0d_addr0", k), {21'b0, sram_addr0}, {21'b0, tbl[k].wa});
        chk($sformatf("v%0d_din0", k), sram_din0, tbl[k].wd);
      end
      if (tbl[k].rv && tbl[k].e_rrdy)
        chk($sformatf("v%0d_addr1", k), {21'b0, sram_addr1}, {21'b0, tbl[k].ra});
    end

    // Backpressure: reads to 0x000..0x009 with rsp_ready held low.
    idx = 0;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      drive(0, 11'h0, 32'h0, 4'h0, 1, 11'(idx), 0);
      if (rd_ready) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_rd_ready_low", {31'b0, rd_ready}, 32'd0);
    chk("bp_head_data", rsp_data, init_word(0));
    for (int c = 0; c < 60 && got < 10; c++) begin
      drive(0, 11'h0, 32'h0, 4'h0, idx < 10, 11'(idx), 1);
      if (rsp_valid) begin
        exp_d = (got == 5) ? 32'hDEADBEEF : init_word(got);
        chk($sformatf("bp_rsp%0d", got), rsp_data, exp_d);
        got++;
      end
      if (rd_valid && rd_ready) idx++;
    end
    chk("bp_all_returned", got, 10);
    chk("bp_all_issued", idx, 10);

    // Reset with one response queued and one read in the SRAM pipeline.
    drive(0, 11'h0, 32'h0, 4'h0, 1, 11'h003, 0);
    chk("rr_accept0", {31'b0, rd_ready}, 32'd1);
    drive(0, 11'h0, 32'h0, 4'h0, 1, 11'h004, 0);
    chk("rr_accept1", {31'b0, rd_ready}, 32'd1);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    wr_valid = 1'b1; wr_addr = 11'h100; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
    rd_valid = 1'b1; rd_addr = 11'h006;
    @(negedge clk);
    chk("rr_busy_before", {31'b0, busy}, 32'd1);
    chk("rr_rd_ready", {31'b0, rd_ready}, 32'd0);
    chk("rr_csb0", {31'b0, sram_csb0}, 32'd1);
    chk("rr_csb1", {31'b0, sram_csb1}, 32'd1);
    @(negedge clk);
    chk("rr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rr_busy", {31'b0, busy}, 32'd0);
    chk("rr_rsp_data", rsp_data, 32'd0);
    drive(0, 11'h0, 32'h0, 4'h0, 0, 11'h0, 1);
    // First cycle with nrst high
    nrst = 1'b1;
    #1;
    chk("rr_first_wr_ready", {31'b0, wr_ready}, 32'd1);
    chk("rr_first_rd_ready", {31'b0, rd_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      drive(0, 11'h0, 32'h0, 4'h0, 0, 11'h0, 1);
      chk($sformatf("rr_no_stale%0d", c), {31'b0, rsp_valid}, 32'd0);
    end
    drive(0, 11'h0, 32'h0, 4'h0, 1, 11'h100, 1);
    drive(0, 11'h0, 32'h0, 4'h0, 0, 11'h0, 1);
    drive(0, 11'h0, 32'h0, 4'h0, 0, 11'h0, 1);
    chk("rr_post_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rr_post_data", rsp_data, init_word(11'h100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
